// File: rtl/mem_req_arbiter.sv
// Round-robin I-cache/D-cache arbiter driving one AXI4 master port.
// One cache-line burst (fill or write-back) in flight at a time.
module mem_req_arbiter #(
    parameter int ID_WIDTH   = 13,
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int BEATS      = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    req_valid,
    input  logic [1:0]                    req_store,
    input  logic [2*ADDR_WIDTH-1:0]       req_addr,
    input  logic [2*BEATS*DATA_WIDTH-1:0] req_wdata,
    output logic [1:0]                    resp_valid,
    output logic                          resp_err,
    output logic [BEATS*DATA_WIDTH-1:0]   resp_rdata,
    output logic [ID_WIDTH-1:0]           m_axi_arid,
    output logic [ADDR_WIDTH-1:0]         m_axi_araddr,
    output logic [7:0]                    m_axi_arlen,
    output logic [2:0]                    m_axi_arsize,
    output logic [1:0]                    m_axi_arburst,
    output logic                          m_axi_arvalid,
    input  logic                          m_axi_arready,
    input  logic [DATA_WIDTH-1:0]         m_axi_rdata,
    input  logic [1:0]                    m_axi_rresp,
    input  logic                          m_axi_rlast,
    input  logic                          m_axi_rvalid,
    output logic                          m_axi_rready,
    output logic [ID_WIDTH-1:0]           m_axi_awid,
    output logic [ADDR_WIDTH-1:0]         m_axi_awaddr,
    output logic [7:0]                    m_axi_awlen,
    output logic [2:0]                    m_axi_awsize,
    output logic [1:0]                    m_axi_awburst,
    output logic                          m_axi_awvalid,
    input  logic                          m_axi_awready,
    output logic [DATA_WIDTH-1:0]         m_axi_wdata,
    output logic [DATA_WIDTH/8-1:0]       m_axi_wstrb,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    input  logic [1:0]                    m_axi_bresp,
    input  logic                          m_axi_bvalid,
    output logic                          m_axi_bready
);

    localparam int LINE = BEATS * DATA_WIDTH;
    localparam int OFF  = $clog2(LINE / 8);
    localparam int CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SZ   = $clog2(DATA_WIDTH / 8);
    localparam logic [CW-1:0] LAST = CW'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] AMASK =
        ~((ADDR_WIDTH'(1) << OFF) - ADDR_WIDTH'(1));

    typedef enum logic [2:0] {
        IDLE, AR, R, AW, W, B, RESP
    } state_t;

    state_t                  state_q, state_d;
    logic                    last_q, last_d;
    logic                    idx_q, idx_d;
    logic                    store_q, store_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [LINE-1:0]         wline_q, wline_d;
    logic [LINE-1:0]         rline_q, rline_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic                    err_q, err_d;
    logic                    gnt;

    // Next-state and datapath updates for the burst sequencer.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        idx_d   = idx_q;
        store_d = store_q;
        addr_d  = addr_q;
        wline_d = wline_q;
        rline_d = rline_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        gnt     = (req_valid == 2'b11) ? ~last_q : req_valid[1];
        unique case (state_q)
            IDLE: begin
                if (req_valid != 2'b00) begin
                    idx_d   = gnt;
                    last_d  = gnt;
                    store_d = req_store[gnt];
                    addr_d  = (gnt ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH]
                                   : req_addr[ADDR_WIDTH-1:0]) & AMASK;
                    wline_d = gnt ? req_wdata[2*LINE-1:LINE]
                                  : req_wdata[LINE-1:0];
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    state_d = req_store[gnt] ? AW : AR;
                end
            end
            AR: if (m_axi_arready) state_d = R;
            R: begin
                if (m_axi_rvalid) begin
                    rline_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = m_axi_rdata;
                    if (cnt_q != LAST) cnt_d = cnt_q + 1'b1;
                    if (m_axi_rresp != 2'b00) err_d = 1'b1;
                    if (m_axi_rlast) state_d = RESP;
                end
            end
            AW: if (m_axi_awready) state_d = W;
            W: begin
                if (m_axi_wready) begin
                    if (cnt_q == LAST) state_d = B;
                    else cnt_d = cnt_q + 1'b1;
                end
            end
            B: begin
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) err_d = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and line registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            idx_q   <= 1'b0;
            store_q <= 1'b0;
            addr_q  <= '0;
            wline_q <= '0;
            rline_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            store_q <= store_d;
            addr_q  <= addr_d;
            wline_q <= wline_d;
            rline_q <= rline_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign m_axi_arid    = ID_WIDTH'(idx_q);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(BEATS - 1);
    assign m_axi_arsize  = 3'(SZ);
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = (state_q == AR);
    assign m_axi_rready  = (state_q == R);

    assign m_axi_awid    = ID_WIDTH'(idx_q);
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(BEATS - 1);
    assign m_axi_awsize  = 3'(SZ);
    assign m_axi_awburst = 2'b01;
    assign m_axi_awvalid = (state_q == AW) && store_q;
    assign m_axi_wdata   = wline_q[cnt_q*DATA_WIDTH +: DATA_WIDTH];
    assign m_axi_wstrb   = '1;
    assign m_axi_wlast   = (state_q == W) && (cnt_q == LAST);
    assign m_axi_wvalid  = (state_q == W);
    assign m_axi_bready  = (state_q == B);

    assign resp_valid = (state_q == RESP) ? (idx_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_err   = (state_q == RESP) && err_q;
    assign resp_rdata = rline_q;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter: fills, write-backs,
// round-robin, error, short burst and mid-burst reset.
module tb_mem_req_arbiter;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid, req_store;
    logic [127:0]  req_addr;
    logic [1023:0] req_wdata;
    logic [1:0]    resp_valid;
    logic          resp_err;
    logic [511:0]  resp_rdata;
    logic [12:0]   arid, awid;
    logic [63:0]   araddr, awaddr;
    logic [7:0]    arlen, awlen;
    logic [2:0]    arsize, awsize;
    logic [1:0]    arburst, awburst;
    logic          arvalid, arready;
    logic [63:0]   rdata;
    logic [1:0]    rresp;
    logic          rlast, rvalid, rready;
    logic          awvalid, awready;
    logic [63:0]   wdata;
    logic [7:0]    wstrb;
    logic          wlast, wvalid, wready;
    logic [1:0]    bresp;
    logic          bvalid, bready;

    int total = 0;
    int bad   = 0;
    logic [63:0] wl [8];

    mem_req_arbiter dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err),
        .resp_rdata(resp_rdata),
        .m_axi_arid(arid), .m_axi_araddr(araddr),
        .m_axi_arlen(arlen), .m_axi_arsize(arsize),
        .m_axi_arburst(arburst), .m_axi_arvalid(arvalid),
        .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp),
        .m_axi_rlast(rlast), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready),
        .m_axi_awid(awid), .m_axi_awaddr(awaddr),
        .m_axi_awlen(awlen), .m_axi_awsize(awsize),
        .m_axi_awburst(awburst), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready),
        .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
        .m_axi_wready(wready),
        .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
        .m_axi_bready(bready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs,
                       input logic [511:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expects AR phase now; checks id/addr, handshakes into R.
    task automatic ar_phase(input string tag, input logic [12:0] id,
                            input logic [63:0] addr);
        chk({tag, "_arvalid"}, arvalid, 1'b1);
        chk({tag, "_arid"}, arid, id);
        chk({tag, "_araddr"}, araddr, addr);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk({tag, "_rready"}, rready, 1'b1);
    endtask

    // Sends n beats base+i; beat errb carries SLVERR; rlast on beat n.
    task automatic r_beats(input int n, input int errb,
                           input logic [63:0] base, input logic [63:0] step);
        for (int i = 0; i < n; i++) begin
            rvalid = 1'b1;
            rdata  = base + step * 64'(i);
            rresp  = (i == errb) ? 2'b10 : 2'b00;
            rlast  = (i == n - 1);
            tick();
        end
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        req_valid = '0; req_store = '0;
        req_addr = '0; req_wdata = '0;
        arready = 0; rvalid = 0; rlast = 0;
        rdata = '0; rresp = '0;
        awready = 0; wready = 0;
        bvalid = 0; bresp = '0;
        tick();
        tick();
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_rready", rready, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_rdata", resp_rdata, 512'd0);
        reset = 1'b0;
        tick();

        // 1: I-cache fill
        req_valid = 2'b10;
        req_addr[127:64] = 64'h1000_0044;
        tick();
        chk("t1_arlen", arlen, 8'd7);
        chk("t1_arsize", arsize, 3'd3);
        chk("t1_arburst", arburst, 2'b01);
        ar_phase("t1", 13'd1, 64'h1000_0040);
        r_beats(8, -1, 64'h11, 64'h11);
        chk("t1_resp_valid", resp_valid, 2'b10);
        chk("t1_resp_err", resp_err, 1'b0);
        chk("t1_rd_lo", resp_rdata[63:0], 64'h11);
        chk("t1_rd_hi", resp_rdata[511:448], 64'h88);
        req_valid = 2'b00;
        tick();
        chk("t1_pulse_end", resp_valid, 2'b00);
        chk("t1_rd_hold", resp_rdata[511:448], 64'h88);

        // 2: round-robin
        req_addr = {64'h4000_0008, 64'h3000_0000};
        req_valid = 2'b11;
        tick();
        ar_phase("t2a", 13'd0, 64'h3000_0000);
        r_beats(8, -1, 64'h100, 64'h1);
        chk("t2a_resp", resp_valid, 2'b01);
        req_valid = 2'b10;
        tick();
        chk("t2_idle_arvalid", arvalid, 1'b0);
        tick();
        ar_phase("t2b", 13'd1, 64'h4000_0000);
        r_beats(8, -1, 64'h200, 64'h1);
        chk("t2b_resp", resp_valid, 2'b10);
        req_valid = 2'b00;
        tick();
        req_valid = 2'b11;
        tick();
        ar_phase("t2c", 13'd0, 64'h3000_0000);
        r_beats(8, -1, 64'h300, 64'h1);
        chk("t2c_resp", resp_valid, 2'b01);
        req_valid = 2'b10;
        tick();
        tick();
        ar_phase("t2d", 13'd1, 64'h4000_0000);
        r_beats(8, -1, 64'h400, 64'h1);
        chk("t2d_resp", resp_valid, 2'b10);
        req_valid = 2'b00;
        tick();

        // 3: D-cache write-back with AW and W stalls
        for (int i = 0; i < 8; i++) begin
            wl[i] = 64'hD000_0000_0000_0000 + 64'h0101 * 64'(i);
            req_wdata[i*64 +: 64] = wl[i];
        end
        req_addr[63:0] = 64'h2000_0000;
        req_store = 2'b01;
        req_valid = 2'b01;
        tick();
        for (int c = 0; c < 3; c++) begin
            chk("t3_awvalid", awvalid, 1'b1);
            chk("t3_awaddr", awaddr, 64'h2000_0000);
            chk("t3_awid", awid, 13'd0);
            chk("t3_wvalid_early", wvalid, 1'b0);
            if (c == 2) awready = 1'b1;
            tick();
        end
        awready = 1'b0;
        chk("t3_awlen", awlen, 8'd7);
        chk("t3_awsize", awsize, 3'd3);
        chk("t3_awburst", awburst, 2'b01);
        chk("t3_wstrb", wstrb, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            chk("t3_wvalid", wvalid, 1'b1);
            chk("t3_wdata", wdata, wl[i]);
            chk("t3_wlast", wlast, i == 7);
            if (i == 2) begin
                wready = 1'b0;
                tick();
                chk("t3_stall_wvalid", wvalid, 1'b1);
                chk("t3_stall_wdata", wdata, wl[2]);
            end
            wready = 1'b1;
            tick();
        end
        wready = 1'b0;
        chk("t3_bready", bready, 1'b1);
        chk("t3_wvalid_off", wvalid, 1'b0);
        bvalid = 1'b1;
        bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("t3_resp", resp_valid, 2'b01);
        chk("t3_err", resp_err, 1'b0);
        req_valid = 2'b00;
        req_store = 2'b00;
        tick();

        // 4: SLVERR on beat 3
        req_addr[63:0] = 64'h5000_0010;
        req_valid = 2'b01;
        tick();
        ar_phase("t4", 13'd0, 64'h5000_0000);
        r_beats(8, 2, 64'h4400, 64'h1);
        chk("t4_resp", resp_valid, 2'b01);
        chk("t4_err", resp_err, 1'b1);
        chk("t4_slice2", resp_rdata[191:128], 64'h4402);
        req_valid = 2'b00;
        tick();

        // 5: early rlast on beat 5
        req_valid = 2'b01;
        tick();
        ar_phase("t5", 13'd0, 64'h5000_0000);
        r_beats(5, -1, 64'h5500, 64'h1);
        chk("t5_resp", resp_valid, 2'b01);
        chk("t5_err", resp_err, 1'b0);
        chk("t5_slice0", resp_rdata[63:0], 64'h5500);
        chk("t5_slice4", resp_rdata[319:256], 64'h5504);
        chk("t5_slice5", resp_rdata[383:320], 64'h4405);
        chk("t5_slice7", resp_rdata[511:448], 64'h4407);
        req_valid = 2'b00;
        tick();

        // 6: reset in the middle of a W burst
        req_addr[63:0] = 64'h2000_0000;
        req_store = 2'b01;
        req_valid = 2'b01;
        tick();
        awready = 1'b1;
        tick();
        awready = 1'b0;
        wready = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_mid_wvalid", wvalid, 1'b1);
        chk("t6_mid_wdata", wdata, wl[3]);
        reset = 1'b1;
        wready = 1'b0;
        req_valid = 2'b00;
        req_store = 2'b00;
        tick();
        chk("t6_wvalid", wvalid, 1'b0);
        chk("t6_awvalid", awvalid, 1'b0);
        chk("t6_bready", bready, 1'b0);
        chk("t6_rdata", resp_rdata, 512'd0);
        reset = 1'b0;
        tick();
        chk("t6_idle_arvalid", arvalid, 1'b0);
        req_addr[127:64] = 64'h6000_0000;
        req_valid = 2'b10;
        tick();
        ar_phase("t6", 13'd1, 64'h6000_0000);
        r_beats(8, -1, 64'h6600, 64'h1);
        chk("t6_resp", resp_valid, 2'b10);
        chk("t6_slice7", resp_rdata[511:448], 64'h6607);
        req_valid = 2'b00;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
